if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//   Fetch initiator for the instruction memory: owns the PC, drives the byte address, and captures
//   the returned 32-bit word into the IF/ID pipeline register. Memory read is combinational;
//   the word is valid in the same cycle as imem_addr. Handles stall, branch redirect/flush,
//   and the dummy halt word (32'hFFFFFFFF) that ends program execution.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   MEM_BYTES  52             instruction memory size in bytes (used only by bounds check)
//   CNT_W      16             width of the delivered-instruction counter
// PORTS
//   clk            in   1      rising-edge clock
//   reset_n        in   1      asynchronous active-low reset
//   stall          in   1      hazard stall from ID: hold PC and IF/ID
//   redirect_valid in   1      branch/jump taken: load redirect_pc, flush IF/ID
//   redirect_pc    in   32     target byte address
//   imem_addr      out  32     byte address to instruction memory (= PC register)
//   imem_instr     in   32     instruction word returned for imem_addr
//   ifid_valid     out  1      IF/ID holds a real instruction
//   ifid_instr     out  32     IF/ID instruction (NOP_WORD when invalid)
//   ifid_pc_plus4  out  32     PC+4 of the captured instruction
//   halted         out  1      halt word fetched (or fault); sticky until reset
//   fault          out  1      out-of-range fetch (FETCH_BOUNDS_CHECK_EN only; else tied 0)
//   instr_count    out  CNT_W  instructions delivered to IF/ID, saturating
// BEHAVIOUR
//   Reset (async, reset_n=0): pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc_plus4=0,
//     halted=0, fault=0, instr_count=0, state=RUN. Deassertion: first fetch next rising edge.
//   imem_addr = pc, combinational from the register; fetch-to-IF/ID latency 1 cycle.
//   States: RUN, HALTED. Per rising edge in RUN, priority high->low:
//     1 redirect_valid: pc<={redirect_pc[31:2],2'b00}; ifid_valid<=0, ifid_instr<=0 (bubble);
//       wins over stall and halt-word detection (halt on wrong path is discarded).
//     2 stall: pc, ifid_*, instr_count all hold.
//     3 imem_instr==HALT_WORD: state->HALTED, ifid_valid<=0, ifid_instr<=0, pc holds.
//     4 otherwise: ifid_instr<=imem_instr, ifid_pc_plus4<=pc+4, ifid_valid<=1, pc<=pc+4,
//       instr_count<=instr_count+1 unless all ones (saturate).
//   HALTED: absorbing; ignores stall/redirect; pc, ifid_pc_plus4, instr_count hold; ifid_valid=0.
//   halted = (state==HALTED), registered. Zero words (nop) are delivered as valid instructions.
//   PC arithmetic modulo 2^32: pc=32'hFFFF_FFFC advances to 0, no flag.
//   Reset mid-operation: all state returns to reset values immediately, regardless of state.
// CONFIGURATION
//   FETCH_BOUNDS_CHECK_EN defined: in RUN, before rules 3/4 (after 1/2), if pc > MEM_BYTES-4
//     -> state HALTED, fault<=1, no IF/ID load, instr_count holds. Redirect to out-of-range
//     target is accepted; fault raises on the following non-stalled cycle.
//   Not defined: no range check, fault constant 0, out-of-range reads use whatever imem returns.
// STRUCTURE
//   Package mips_pipe_pkg: HALT_WORD=32'hFFFF_FFFF, NOP_WORD=32'h0, fetch_state_t {RUN,HALTED}.
//   Sub-module fetch_pc_next: combinational next-PC mux (redirect/stall/halt/increment),
//   outputs next_pc and load-IF/ID strobe; top holds registers, state and counter.
// TESTING
//   Reset then 8 free-running cycles on standard program -> imem_addr 0,4,..,28; ifid_instr
//     a1020000, 810afffc, ... one cycle after each address; instr_count=8.
//   stall=1 for 3 cycles at pc=8 -> imem_addr stays 8, ifid_instr stays 810afffc, count holds.
//   redirect_valid=1, redirect_pc=32'h13 with stall=1 at pc=12 -> pc=16 next cycle, ifid_valid=0,
//     ifid_instr=0, then 01224820 delivered.
//   Run to pc=48 (word FFFFFFFF) -> halted=1 next edge, ifid_valid=0, pc stays 48; later
//     redirect/stall ignored; count=12 (incl. 4 nops).
//   Force pc=FFFF_FFFC via redirect, imem_instr=0 -> pc wraps to 0, ifid_pc_plus4=0.
//   FETCH_BOUNDS_CHECK_EN, redirect_pc=52 -> next cycle fault=1, halted=1, ifid_valid=0;
//     pull reset_n low mid-run -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage types and constants.
// Build option: FETCH_BOUNDS_CHECK_EN enables the fetch range check.
package mips_pipe_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory bus and IF/ID register bundle.
// Master is the fetch controller, slave is memory/decode.
interface if_fetch_ctrl_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;

    modport master (
        output imem_addr,
        input  imem_instr,
        output ifid_valid,
        output ifid_instr,
        output ifid_pc_plus4
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  ifid_valid,
        input  ifid_instr,
        input  ifid_pc_plus4
    );

endinterface

// File: rtl/if_fetch_ctrl_pc_next.sv
// Next-PC mux and IF/ID load/flush decision for the fetch stage.
// Range check active only with FETCH_BOUNDS_CHECK_EN defined.
module fetch_pc_next
    import mips_pipe_pkg::*;
#(
    parameter int MEM_BYTES = 52
) (
    input  fetch_state_t state,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic [31:0]  pc,
    input  logic [31:0]  imem_instr,
    output logic [31:0]  next_pc,
    output logic         ifid_load,
    output logic         ifid_flush,
    output logic         halt_req,
    output logic         fault_req
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);

    logic oob;
    assign oob = CHK && (pc > LAST);

    // Priority: halted, redirect, stall, range fault, halt word, advance.
    always_comb begin
        next_pc    = pc;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        halt_req   = 1'b0;
        fault_req  = 1'b0;
        if (state == HALTED) begin
            next_pc = pc;
        end else if (redirect_valid) begin
            next_pc    = {redirect_pc[31:2], 2'b00};
            ifid_flush = 1'b1;
        end else if (stall) begin
            next_pc = pc;
        end else if (oob) begin
            halt_req   = 1'b1;
            fault_req  = 1'b1;
            ifid_flush = 1'b1;
        end else if (imem_instr == HALT_WORD) begin
            halt_req   = 1'b1;
            ifid_flush = 1'b1;
        end else begin
            next_pc   = pc + 32'd4;
            ifid_load = 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: PC, IF/ID register, halt state, delivered count.
// Build option: FETCH_BOUNDS_CHECK_EN raises fault on out-of-range fetch.
module if_fetch_ctrl
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 52,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    if_fetch_ctrl_if.master  bus,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [31:0]      pc_q;
    logic             vld_q;
    logic [31:0]      instr_q;
    logic [31:0]      pp4_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;

    logic [31:0]      next_pc;
    logic             ifid_load;
    logic             ifid_flush;
    logic             halt_req;
    logic             fault_req;

    fetch_pc_next #(
        .MEM_BYTES (MEM_BYTES)
    ) u_pc_next (
        .state          (state_q),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc_q),
        .imem_instr     (bus.imem_instr),
        .next_pc        (next_pc),
        .ifid_load      (ifid_load),
        .ifid_flush     (ifid_flush),
        .halt_req       (halt_req),
        .fault_req      (fault_req)
    );

    // Next state: RUN moves to HALTED on halt word or fault.
    always_comb begin
        state_d = state_q;
        if (halt_req) begin
            state_d = HALTED;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, IF/ID register, saturating counter and sticky fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            instr_q <= NOP_WORD;
            pp4_q   <= 32'h0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q <= next_pc;
            if (ifid_flush) begin
                vld_q   <= 1'b0;
                instr_q <= NOP_WORD;
            end else if (ifid_load) begin
                vld_q   <= 1'b1;
                instr_q <= bus.imem_instr;
                pp4_q   <= pc_q + 32'd4;
            end
            if (ifid_load && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fault_req) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.ifid_valid    = vld_q;
    assign bus.ifid_instr    = instr_q;
    assign bus.ifid_pc_plus4 = pp4_q;
    assign halted            = (state_q == HALTED);
    assign fault             = fault_q;
    assign instr_count       = cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed program walk plus random
// stall/redirect/reset traffic against a behavioural fetch model.
module tb_if_fetch_ctrl;
    import mips_pipe_pkg::*;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [31:0] PROG [13] = '{
        32'ha1020000, 32'h810afffc, 32'h8d090004, 32'h00000000,
        32'h01224820, 32'h00000000, 32'had0a0008, 32'h00000000,
        32'h1000fffe, 32'h00000000, 32'h2009000a, 32'h01095020,
        32'hffffffff
    };

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic [31:0]   oob_word = 32'h0;
    logic          halted;
    logic          fault;
    logic [CW-1:0] instr_count;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(
        .RESET_PC  (32'h0),
        .MEM_BYTES (52),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .halted         (halted),
        .fault          (fault),
        .instr_count    (instr_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (bus.imem_addr < 32'd52) bus.imem_instr = PROG[bus.imem_addr[5:2]];
        else                        bus.imem_instr = oob_word;
    end

    typedef struct {
        logic [31:0]   pc;
        logic          v;
        logic [31:0]   instr;
        logic [31:0]   pp4;
        logic          h;
        logic          f;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0]   m_pc;
    logic          m_v;
    logic [31:0]   m_instr;
    logic [31:0]   m_pp4;
    logic          m_h;
    logic          m_f;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (a < 32'd52) return PROG[a[5:2]];
        return oob_word;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_v = 0; m_instr = 0; m_pp4 = 0;
        m_h = 0; m_f = 0; m_cnt = '0;
    endtask

    task automatic chk_reset();
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.ifid_valid), 32'h0);
        chk("rst_instr", bus.ifid_instr, 32'h0);
        chk("rst_pp4", bus.ifid_pc_plus4, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_count", 32'(instr_count), 32'h0);
    endtask

    // Called at a falling edge: drive inputs, predict the next edge, wait a cycle.
    task automatic step(input logic st, input logic rv,
                        input logic [31:0] rp, input logic [31:0] ow);
        logic [31:0] w;
        bit          oob;
        exp_t        e;
        stall = st; redirect_valid = rv; redirect_pc = rp; oob_word = ow;
        w = memrd(m_pc);
`ifdef FETCH_BOUNDS_CHECK_EN
        oob = (m_pc > 32'd48);
`else
        oob = 1'b0;
`endif
        if (!m_h) begin
            if (rv) begin
                m_pc = rp & ~32'd3; m_v = 0; m_instr = 0;
            end else if (st) begin
                m_pc = m_pc;
            end else if (oob) begin
                m_h = 1; m_f = 1; m_v = 0; m_instr = 0;
            end else if (w == 32'hffffffff) begin
                m_h = 1; m_v = 0; m_instr = 0;
            end else begin
                m_instr = w; m_pp4 = m_pc + 4; m_v = 1; m_pc = m_pc + 4;
                if (m_cnt != CMAX) m_cnt = m_cnt + 1;
            end
        end
        e = '{m_pc, m_v, m_instr, m_pp4, m_h, m_f, m_cnt};
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        #1;
        chk_reset();
        model_reset();
        q.delete();
        @(negedge clk);
        reset_n = 1;
    endtask

    // Monitor: compare each predicted edge just after it happens.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("addr", bus.imem_addr, e.pc);
                chk("valid", 32'(bus.ifid_valid), 32'(e.v));
                chk("instr", bus.ifid_instr, e.instr);
                if (e.v) chk("pp4", bus.ifid_pc_plus4, e.pp4);
                chk("halted", 32'(halted), 32'(e.h));
                chk("fault", 32'(fault), 32'(e.f));
                chk("count", 32'(instr_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        chk_reset();
        @(negedge clk);
        reset_n = 1;

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("d_instr1", bus.ifid_instr, 32'h810afffc);
        repeat (6) step(0, 0, 0, 0);
        chk("d_addr8", bus.imem_addr, 32'd32);
        chk("d_cnt8", 32'(instr_count), 32'd8);
        repeat (5) step(0, 0, 0, 0);
        chk("d_halt", 32'(halted), 32'd1);
        chk("d_halt_pc", bus.imem_addr, 32'd48);
        chk("d_halt_v", 32'(bus.ifid_valid), 32'd0);
        chk("d_cnt12", 32'(instr_count), 32'd12);
        step(1, 1, 32'd8, 0);
        step(0, 1, 32'd4, 0);
        chk("d_abs_pc", bus.imem_addr, 32'd48);
        chk("d_abs_h", 32'(halted), 32'd1);

        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        chk("s_addr", bus.imem_addr, 32'd8);
        chk("s_instr", bus.ifid_instr, 32'h810afffc);
        chk("s_cnt", 32'(instr_count), 32'd2);
        step(0, 0, 0, 0);
        step(1, 1, 32'h13, 0);
        chk("r_addr", bus.imem_addr, 32'd16);
        chk("r_valid", 32'(bus.ifid_valid), 32'd0);
        chk("r_instr", bus.ifid_instr, 32'd0);
        step(0, 0, 0, 0);
        chk("r_deliv", bus.ifid_instr, 32'h01224820);
        chk("r_pp4", bus.ifid_pc_plus4, 32'd20);

        do_reset();
        step(0, 1, 32'hffff_fffc, 0);
        step(0, 0, 0, 0);
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("w_fault", 32'(fault), 32'd1);
        chk("w_halt", 32'(halted), 32'd1);
`else
        chk("w_addr", bus.imem_addr, 32'd0);
        chk("w_pp4", bus.ifid_pc_plus4, 32'd0);
        chk("w_valid", 32'(bus.ifid_valid), 32'd1);
`endif

`ifdef FETCH_BOUNDS_CHECK_EN
        do_reset();
        step(0, 1, 32'd52, 0);
        chk("b_nofault", 32'(fault), 32'd0);
        step(0, 0, 0, 0);
        chk("b_fault", 32'(fault), 32'd1);
        chk("b_halt", 32'(halted), 32'd1);
        chk("b_valid", 32'(bus.ifid_valid), 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic        st;
            logic        rv;
            logic [31:0] rp;
            logic [31:0] ow;
            if ((m_h && $urandom_range(0, 9) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                st = ($urandom_range(0, 99) < 25);
                rv = ($urandom_range(0, 99) < 12);
                case ($urandom_range(0, 3))
                    0, 1:    rp = 32'($urandom_range(0, 51));
                    2:       rp = $urandom;
                    default: rp = 32'hffff_fffc;
                endcase
                ow = ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : $urandom;
                step(st, rv, rp, ow);
            end
        end

        @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
